// File: rtl/rdw_stage_pkg.sv
// Shared definitions for the read-data-wait stage: mem_op bit positions and
// the load align/extend helper used by both the aligner and forwarding paths.
package rdw_stage_pkg;

  localparam int unsigned LD_B  = 0;
  localparam int unsigned LD_H  = 1;
  localparam int unsigned LD_W  = 2;
  localparam int unsigned LD_BU = 3;
  localparam int unsigned LD_HU = 4;
  localparam int unsigned ST_B  = 5;
  localparam int unsigned ST_H  = 6;
  localparam int unsigned ST_W  = 7;

  // Anything that is not a byte/half load returns the raw word unchanged.
  function automatic logic [31:0] load_extend(
    input logic [31:0]    raw,
    input logic [LD_HU:0] op,
    input logic [1:0]     addr
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (addr)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      default: b = raw[31:24];
    endcase
    h = addr[1] ? raw[31:16] : raw[15:0];
    if (op[LD_B])       load_extend = {{24{b[7]}}, b};
    else if (op[LD_BU]) load_extend = {24'b0, b};
    else if (op[LD_H])  load_extend = {{16{h[15]}}, h};
    else if (op[LD_HU]) load_extend = {16'b0, h};
    else                load_extend = raw;
  endfunction

endpackage

// File: rtl/rdw_load_align.sv
// Combinational load-data aligner/extender selected by mem_op and the low
// address bits.
import rdw_stage_pkg::*;

module rdw_load_align (
  input  logic [31:0] raw,
  input  logic [7:0]  mem_op,
  input  logic [1:0]  addr,
  output logic [31:0] aligned
);

  logic unused_store_bits;
  assign unused_store_bits = ^mem_op[ST_W:ST_B];

  assign aligned = load_extend(raw, mem_op[LD_HU:0], addr);

endmodule

// File: rtl/rdw_stage.sv
// Read-data-wait stage: holds memory ops until their response arrives, aligns
// load data for WB, and swallows responses orphaned by a pipeline flush.
import rdw_stage_pkg::*;

module rdw_stage #(
  parameter logic [31:0] RESET_PC  = 32'h1c000000,
  parameter int unsigned DISCARD_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  input  logic        ex_flush,
  input  logic        ertn_flush,
  input  logic        tlb_flush,
  input  logic [31:0] PC,
  input  logic [31:0] alu_result,
  input  logic [7:0]  mem_op,
  input  logic        res_from_mem,
  input  logic        mem_we,
  input  logic        gr_we,
  input  logic [4:0]  dest,
  input  logic        has_exception,
  input  logic        ertn,
  input  logic        tlb,
  input  logic        data_valid_in,
  input  logic [31:0] data_in,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic        RDW_flush,
  output logic        RDW_data_valid,
  output logic        RDW_this_tlb_refetch,
  output logic [31:0] result_bypass,
  output logic        bypass_ready,
  output logic [31:0] PC_out,
  output logic [31:0] result_out,
  output logic        gr_we_out,
  output logic [4:0]  dest_out,
  output logic        has_exception_out,
  output logic        ertn_out
);

  logic                 buf_valid;
  logic [31:0]          buf_data;
  logic [DISCARD_W-1:0] discard_cnt;

  logic        flush_any, need, resp_live, got, ready_go, accept, buf_set;
  logic        cnt_inc, cnt_dec;
  logic [31:0] raw, load_data, final_result;

  assign flush_any = ex_flush | ertn_flush | tlb_flush;
  assign need      = in_valid & (res_from_mem | mem_we) & ~has_exception;
  // A response arriving while orphans are outstanding belongs to a flushed op.
  assign resp_live = data_ok & (discard_cnt == '0);
  assign got       = data_valid_in | buf_valid | resp_live;
  assign ready_go  = ~in_valid | ~need | got;
  assign accept    = in_valid & ready_go & out_ready;
  assign in_ready  = ~in_valid | (ready_go & out_ready);
  assign buf_set   = resp_live & need & ~data_valid_in & ~buf_valid & ~out_ready;

  assign cnt_inc = flush_any & need & ~got;
  assign cnt_dec = data_ok & (discard_cnt != '0);

  assign raw = data_valid_in ? data_in : (buf_valid ? buf_data : rdata);

  rdw_load_align u_align (
    .raw     (raw),
    .mem_op  (mem_op),
    .addr    (alu_result[1:0]),
    .aligned (load_data)
  );

  assign final_result         = res_from_mem ? load_data : alu_result;
  assign result_bypass        = final_result;
  assign bypass_ready         = ~in_valid | ~res_from_mem | got;
  assign RDW_flush            = in_valid & (has_exception | ertn);
  assign RDW_data_valid       = in_valid & (data_valid_in | buf_valid);
  assign RDW_this_tlb_refetch = in_valid & tlb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (buf_set) begin
      buf_valid <= 1'b1;
      buf_data  <= rdata;
    end else if (accept) begin
      buf_valid <= 1'b0;
    end
  end

  // Simultaneous increment and decrement cancel; increments stop at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      discard_cnt <= '0;
    end else if (cnt_inc && !cnt_dec) begin
      if (discard_cnt != '1) discard_cnt <= discard_cnt + DISCARD_W'(1);
    end else if (cnt_dec && !cnt_inc) begin
      discard_cnt <= discard_cnt - DISCARD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
    end else if (out_ready) begin
      out_valid <= in_valid & ready_go & ~flush_any;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC_out            <= RESET_PC;
      result_out        <= '0;
      gr_we_out         <= 1'b0;
      dest_out          <= '0;
      has_exception_out <= 1'b0;
      ertn_out          <= 1'b0;
    end else if (accept) begin
      PC_out            <= PC;
      result_out        <= final_result;
      gr_we_out         <= gr_we;
      dest_out          <= dest;
      has_exception_out <= has_exception;
      ertn_out          <= ertn;
    end
  end

  a_stray_resp_no_buf: assert property (
    @(posedge clk) disable iff (!rst)
      (data_ok && !need && discard_cnt == '0 && !buf_valid) |=> !buf_valid
  );

endmodule
